// File: rtl/cpu_types_pkg.sv
// Shared types for the MEM/WB latch: load-size encoding and capture FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } memlatch_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational sub-word lane select with sign/zero extension (little-endian lanes).
module load_extract
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    localparam int OFF_W = $clog2(WORD_W / 8)
) (
    input  logic [WORD_W-1:0] ld_val,
    input  logic [1:0]        ld_size,
    input  logic              ld_sign,
    input  logic [OFF_W-1:0]  ld_off,
    output logic [WORD_W-1:0] ext
);

    localparam int LANES  = WORD_W / 8;
    localparam int HALVES = WORD_W / 16;

    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [OFF_W-1:0] half_idx;

    // Halfword index drops the byte-within-half bit.
    assign half_idx = ld_off >> 1;

    always_comb begin
        byte_v = '0;
        half_v = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(ld_off) == i) byte_v = ld_val[8*i +: 8];
        end
        for (int i = 0; i < HALVES; i++) begin
            if (int'(half_idx) == i) half_v = ld_val[16*i +: 16];
        end
        case (ld_size)
            LD_BYTE: ext = {{(WORD_W-8){ld_sign & byte_v[7]}}, byte_v};
            LD_HALF: ext = {{(WORD_W-16){ld_sign & half_v[15]}}, half_v};
            default: ext = ld_val;
        endcase
    end

endmodule

// File: rtl/mem_wb_latch_p.sv
// MEM/WB pipeline register with a D-cache load capture FSM and optional sub-word extraction.
//
//  state | meaning
//  IDLE  | no captured load data; a hit with en bypasses straight to the stage
//  WAIT  | load stalled, data not yet returned by the dcache
//  HELD  | load data captured in cap_q, waiting for the stage to advance
module mem_wb_latch_p
    import cpu_types_pkg::*;
#(
    parameter int WORD_W         = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int JADDR_W        = 26,
    parameter int ENABLE_SUBWORD = 1,
    localparam int OFF_W         = $clog2(WORD_W / 8)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  mem_read,
    input  logic                  dhit,
    input  logic [WORD_W-1:0]     dload,
    input  logic [1:0]            ld_size,
    input  logic                  ld_sign,
    input  logic [OFF_W-1:0]      ld_off,
    input  logic [WORD_W-1:0]     pc_plus_4,
    input  logic [WORD_W-1:0]     portout,
    input  logic                  regWEN,
    input  logic                  halt,
    input  logic                  Jump,
    input  logic                  JAL,
    input  logic                  MemtoReg,
    input  logic [REG_ADDR_W-1:0] wsel,
    input  logic [JADDR_W-1:0]    jaddr,
    output logic [WORD_W-1:0]     out_pc_plus_4,
    output logic [WORD_W-1:0]     out_portout,
    output logic                  out_regWEN,
    output logic                  out_halt,
    output logic                  out_Jump,
    output logic                  out_JAL,
    output logic                  out_MemtoReg,
    output logic [REG_ADDR_W-1:0] out_wsel,
    output logic [JADDR_W-1:0]    out_jaddr,
    output logic [WORD_W-1:0]     out_dload,
    output logic                  ld_pending,
    output logic                  ld_err
);

    memlatch_state_t   state, state_n;
    logic [WORD_W-1:0] cap_q, cap_n;
    logic [WORD_W-1:0] ld_val, ext;
    logic              err_n;

    // Same-cycle hit wins over captured data so a hit with en costs no latency.
    assign ld_val     = dhit ? dload : ((state == HELD) ? cap_q : '0);
    assign ld_pending = mem_read & (state != HELD) & ~dhit;

    generate
        if (ENABLE_SUBWORD != 0) begin : g_sub
            load_extract #(.WORD_W(WORD_W)) u_extract (
                .ld_val  (ld_val),
                .ld_size (ld_size),
                .ld_sign (ld_sign),
                .ld_off  (ld_off),
                .ext     (ext)
            );
        end else begin : g_nosub
            logic unused_sub;
            assign ext        = ld_val;
            assign unused_sub = ^{ld_size, ld_sign, ld_off};
        end
    endgenerate

    always_comb begin
        state_n = state;
        cap_n   = cap_q;
        err_n   = ld_err;
        case (state)
            IDLE: begin
                if (mem_read && !en) begin
                    if (dhit) begin
                        state_n = HELD;
                        cap_n   = dload;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (en) begin
                    state_n = IDLE;
                end else if (dhit) begin
                    state_n = HELD;
                    cap_n   = dload;
                end
            end
            HELD: begin
                if (en) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Advancing past a load that never got its data is a hazard-unit bug; flag it.
        if (en && !dhit && ((state == WAIT) || (state == IDLE && mem_read))) err_n = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cap_q         <= '0;
            ld_err        <= 1'b0;
            out_pc_plus_4 <= '0;
            out_portout   <= '0;
            out_regWEN    <= 1'b0;
            out_halt      <= 1'b0;
            out_Jump      <= 1'b0;
            out_JAL       <= 1'b0;
            out_MemtoReg  <= 1'b0;
            out_wsel      <= '0;
            out_jaddr     <= '0;
            out_dload     <= '0;
        end else if (flush) begin
            state         <= IDLE;
            cap_q         <= '0;
            out_pc_plus_4 <= '0;
            out_portout   <= '0;
            out_regWEN    <= 1'b0;
            out_halt      <= 1'b0;
            out_Jump      <= 1'b0;
            out_JAL       <= 1'b0;
            out_MemtoReg  <= 1'b0;
            out_wsel      <= '0;
            out_jaddr     <= '0;
            out_dload     <= '0;
        end else begin
            state  <= state_n;
            cap_q  <= cap_n;
            ld_err <= err_n;
            if (en) begin
                out_pc_plus_4 <= pc_plus_4;
                out_portout   <= portout;
                out_regWEN    <= regWEN;
                out_halt      <= halt;
                out_Jump      <= Jump;
                out_JAL       <= JAL;
                out_MemtoReg  <= MemtoReg;
                out_wsel      <= wsel;
                out_jaddr     <= jaddr;
                out_dload     <= MemtoReg ? ext : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_latch_p.sv
// Directed and randomized checks of mem_wb_latch_p (32-bit sub-word build and 64-bit full-word build).
module tb_mem_wb_latch_p;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en, flush, mem_read, dhit;
    logic [31:0] dload, pc_plus_4, portout;
    logic [1:0]  ld_size;
    logic        ld_sign;
    logic [1:0]  ld_off;
    logic        regWEN, halt, Jump, JAL, MemtoReg;
    logic [4:0]  wsel;
    logic [25:0] jaddr;

    logic [31:0] o_pc, o_port, o_dload;
    logic        o_regWEN, o_halt, o_Jump, o_JAL, o_MemtoReg;
    logic [4:0]  o_wsel;
    logic [25:0] o_jaddr;
    logic        pend, err;

    logic [63:0] dload6, pc6, port6;
    logic [2:0]  off6;
    logic [63:0] o6_pc, o6_port, o6_dload;
    logic        o6_regWEN, o6_halt, o6_Jump, o6_JAL, o6_MemtoReg;
    logic [4:0]  o6_wsel;
    logic [25:0] o6_jaddr;
    logic        pend6, err6;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  off;
        logic [31:0] d;
        logic [31:0] e;
    } t4_t;

    t4_t t4_tab[7] = '{
        '{2'd0, 1'b1, 2'd2, 32'h0080FF00, 32'hFFFFFF80},
        '{2'd0, 1'b0, 2'd2, 32'h0080FF00, 32'h00000080},
        '{2'd1, 1'b1, 2'd2, 32'h80000000, 32'hFFFF8000},
        '{2'd1, 1'b0, 2'd3, 32'h80000000, 32'h00008000},
        '{2'd0, 1'b1, 2'd1, 32'h0080FF00, 32'hFFFFFFFF},
        '{2'd1, 1'b1, 2'd0, 32'h00017FFF, 32'h00007FFF},
        '{2'd3, 1'b1, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D}
    };

    always #5 CLK = ~CLK;

    mem_wb_latch_p dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .mem_read(mem_read), .dhit(dhit),
        .dload(dload), .ld_size(ld_size), .ld_sign(ld_sign), .ld_off(ld_off),
        .pc_plus_4(pc_plus_4), .portout(portout), .regWEN(regWEN), .halt(halt),
        .Jump(Jump), .JAL(JAL), .MemtoReg(MemtoReg), .wsel(wsel), .jaddr(jaddr),
        .out_pc_plus_4(o_pc), .out_portout(o_port), .out_regWEN(o_regWEN),
        .out_halt(o_halt), .out_Jump(o_Jump), .out_JAL(o_JAL), .out_MemtoReg(o_MemtoReg),
        .out_wsel(o_wsel), .out_jaddr(o_jaddr), .out_dload(o_dload),
        .ld_pending(pend), .ld_err(err)
    );

    mem_wb_latch_p #(.WORD_W(64), .ENABLE_SUBWORD(0)) dut64 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .mem_read(mem_read), .dhit(dhit),
        .dload(dload6), .ld_size(ld_size), .ld_sign(ld_sign), .ld_off(off6),
        .pc_plus_4(pc6), .portout(port6), .regWEN(regWEN), .halt(halt),
        .Jump(Jump), .JAL(JAL), .MemtoReg(MemtoReg), .wsel(wsel), .jaddr(jaddr),
        .out_pc_plus_4(o6_pc), .out_portout(o6_port), .out_regWEN(o6_regWEN),
        .out_halt(o6_halt), .out_Jump(o6_Jump), .out_JAL(o6_JAL), .out_MemtoReg(o6_MemtoReg),
        .out_wsel(o6_wsel), .out_jaddr(o6_jaddr), .out_dload(o6_dload),
        .ld_pending(pend6), .ld_err(err6)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [63:0] obs);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, sb_q.pop_front());
        end
    endtask

    task automatic clr_in();
        en = 0; flush = 0; mem_read = 0; dhit = 0;
        dload = '0; pc_plus_4 = '0; portout = '0;
        ld_size = 2'd2; ld_sign = 0; ld_off = '0;
        regWEN = 0; halt = 0; Jump = 0; JAL = 0; MemtoReg = 0;
        wsel = '0; jaddr = '0;
        dload6 = '0; pc6 = '0; port6 = '0; off6 = '0;
    endtask

    initial begin
        int  ms;
        logic [63:0] mcap, mout, mpc, lv;
        logic m_pend, new_instr;

        // T1: reset with every input high
        RST = 1; en = 1; flush = 1; mem_read = 1; dhit = 1;
        dload = '1; pc_plus_4 = '1; portout = '1; ld_size = '1; ld_sign = 1; ld_off = '1;
        regWEN = 1; halt = 1; Jump = 1; JAL = 1; MemtoReg = 1; wsel = '1; jaddr = '1;
        dload6 = '1; pc6 = '1; port6 = '1; off6 = '1;
        tick(); tick();
        chk("t1_dload", 64'(o_dload), 64'h0);
        chk("t1_pc", 64'(o_pc), 64'h0);
        chk("t1_port", 64'(o_port), 64'h0);
        chk("t1_ctrl", 64'({o_regWEN, o_halt, o_Jump, o_JAL, o_MemtoReg}), 64'h0);
        chk("t1_wsel_jaddr", 64'({o_wsel, o_jaddr}), 64'h0);
        chk("t1_pending", 64'(pend), 64'h0);
        chk("t1_err", 64'(err), 64'h0);
        RST = 0;
        clr_in();

        // T2: same-cycle hit with en, full word
        mem_read = 1; dhit = 1; en = 1; dload = 32'hDEADBEEF; MemtoReg = 1; ld_size = 2'd2;
        pc_plus_4 = 32'h00001004; portout = 32'hA5A50001; wsel = 5'd7; jaddr = 26'h1234567;
        regWEN = 1; Jump = 1;
        sb_q.push_back(64'h00000000DEADBEEF);
        tick();
        sb_check("t2_dload", 64'(o_dload));
        chk("t2_pc", 64'(o_pc), 64'h1004);
        chk("t2_port", 64'(o_port), 64'hA5A50001);
        chk("t2_ctrl", 64'({o_regWEN, o_halt, o_Jump, o_JAL, o_MemtoReg}), 64'b10101);
        chk("t2_wsel_jaddr", 64'({o_wsel, o_jaddr}), 64'({5'd7, 26'h1234567}));
        chk("t2_state", 64'(dut.state), 64'(cpu_types_pkg::IDLE));

        // T3: hit during stall is captured, later hit ignored, released on en
        en = 0; dhit = 1; dload = 32'h12345678;
        tick();
        chk("t3_state_held", 64'(dut.state), 64'(cpu_types_pkg::HELD));
        chk("t3_hold_out", 64'(o_dload), 64'hDEADBEEF);
        dload = 32'hFFFFFFFF;
        tick();
        dhit = 0; en = 1; dload = '0;
        #1;
        chk("t3_pending", 64'(pend), 64'h0);
        sb_q.push_back(64'h12345678);
        tick();
        sb_check("t3_dload", 64'(o_dload));
        chk("t3_state_idle", 64'(dut.state), 64'(cpu_types_pkg::IDLE));
        chk("t3_err", 64'(err), 64'h0);

        // T4: sub-word extraction table
        for (int i = 0; i < 7; i++) begin
            mem_read = 1; dhit = 1; en = 1; MemtoReg = 1;
            ld_size = t4_tab[i].sz; ld_sign = t4_tab[i].sg; ld_off = t4_tab[i].off;
            dload = t4_tab[i].d;
            sb_q.push_back(64'(t4_tab[i].e));
            tick();
            sb_check($sformatf("t4_ext%0d", i), 64'(o_dload));
        end
        MemtoReg = 0; ld_size = 2'd2; dload = 32'h11112222;
        sb_q.push_back(64'h0);
        tick();
        sb_check("t4_no_memtoreg", 64'(o_dload));

        // T5: flush in WAIT discards the hit; then an illegal advance sets ld_err
        clr_in();
        mem_read = 1; MemtoReg = 1;
        tick();
        chk("t5_state_wait", 64'(dut.state), 64'(cpu_types_pkg::WAIT));
        chk("t5_pending", 64'(pend), 64'h1);
        flush = 1; en = 1; dhit = 1; dload = 32'hAAAA5555; pc_plus_4 = 32'h2000;
        sb_q.push_back(64'h0);
        tick();
        sb_check("t5_flush_dload", 64'(o_dload));
        chk("t5_flush_pc", 64'(o_pc), 64'h0);
        chk("t5_flush_state", 64'(dut.state), 64'(cpu_types_pkg::IDLE));
        chk("t5_err_pre", 64'(err), 64'h0);
        flush = 0; dhit = 0; dload = '0;
        sb_q.push_back(64'h0);
        tick();
        sb_check("t5_nodata_dload", 64'(o_dload));
        chk("t5_nodata_pc", 64'(o_pc), 64'h2000);
        chk("t5_err_set", 64'(err), 64'h1);
        flush = 1; en = 0; mem_read = 0;
        tick();
        chk("t5_err_sticky", 64'(err), 64'h1);

        // Reset while HELD drops the captured data
        clr_in();
        RST = 1; tick(); RST = 0;
        chk("rst_err_clear", 64'(err), 64'h0);
        mem_read = 1; dhit = 1; dload = 32'h55AA55AA;
        tick();
        chk("rst_pre_held", 64'(dut.state), 64'(cpu_types_pkg::HELD));
        RST = 1; tick(); RST = 0;
        chk("rst_state_idle", 64'(dut.state), 64'(cpu_types_pkg::IDLE));
        mem_read = 0; dhit = 0; en = 1; MemtoReg = 1; dload = '0;
        sb_q.push_back(64'h0);
        tick();
        sb_check("rst_held_lost", 64'(o_dload));
        chk("rst_err_after", 64'(err), 64'h0);

        // T6: 64-bit full-word build under random legal stimulus
        clr_in();
        RST = 1; tick(); tick(); RST = 0;
        ms = 0; mcap = '0; mout = '0; mpc = '0; new_instr = 1;
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 9) == 0);
            if (new_instr) mem_read = $urandom_range(0, 1) != 0;
            dhit = ($urandom_range(0, 9) < 4);
            dload6 = {$urandom, $urandom};
            pc6 = {$urandom, $urandom};
            MemtoReg = ($urandom_range(0, 3) != 0);
            ld_size = 2'($urandom_range(0, 3));
            ld_sign = $urandom_range(0, 1) != 0;
            off6 = 3'($urandom_range(0, 7));
            m_pend = mem_read && (ms != 2) && !dhit;
            en = ($urandom_range(0, 1) != 0) && !m_pend;
            #1;
            chk("t6_pending", 64'(pend6), 64'(m_pend));
            if (flush) begin
                mout = '0; mpc = '0; ms = 0; mcap = '0;
            end else begin
                lv = dhit ? dload6 : ((ms == 2) ? mcap : 64'h0);
                if (en) begin
                    mout = MemtoReg ? lv : 64'h0;
                    mpc = pc6;
                end
                case (ms)
                    0: if (mem_read && !en) begin
                        if (dhit) begin ms = 2; mcap = dload6; end
                        else ms = 1;
                    end
                    1: if (en) ms = 0;
                       else if (dhit) begin ms = 2; mcap = dload6; end
                    default: if (en) ms = 0;
                endcase
            end
            sb_q.push_back(mout);
            new_instr = en || flush;
            tick();
            sb_check("t6_dload", o6_dload);
            chk("t6_pc", o6_pc, mpc);
        end
        chk("t6_err", 64'(err6), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
